// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller slaved to the north-south light phase.
// Grants a WALK/flashing DON'T WALK sequence at NS green entry when a request
// is already latched; any loss of green or an illegal phase forces DON'T WALK.
module ped_crossing_ctrl #(
  parameter int WALK_CYCLES  = 3,
  parameter int FLASH_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light_ns,
  input  logic       ped_req,
  output logic       walk,
  output logic       flash,
  output logic       dont_walk,
  output logic [3:0] countdown,
  output logic       req_pending,
  output logic       aborted,
  output logic       fault
);

  typedef enum logic [1:0] {
    S_DONT_WALK = 2'd0,
    S_WALK      = 2'd1,
    S_FLASH     = 2'd2
  } state_t;

  localparam logic [1:0] L_GREEN   = 2'b01;
  localparam logic [1:0] L_ILLEGAL = 2'b11;
  localparam logic [3:0] WALK_LAST  = 4'(WALK_CYCLES - 1);
  localparam logic [3:0] FLASH_INIT = 4'(FLASH_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] light_prev_q, light_prev_d;
  logic       req_prev_q, req_prev_d;
  logic       req_pending_q, req_pending_d;
  logic [3:0] walk_cnt_q, walk_cnt_d;
  logic [3:0] countdown_q, countdown_d;
  logic       aborted_q, aborted_d;
  logic       fault_q, fault_d;

  logic req_rise;
  logic green_entry;
  logic in_walk_or_flash;

  assign req_rise         = ped_req & ~req_prev_q;
  assign green_entry      = (light_ns == L_GREEN) && (light_prev_q != L_GREEN);
  assign in_walk_or_flash = (state_q == S_WALK) || (state_q == S_FLASH);

  // Next-state, request latch, countdown and safety overrides
  always_comb begin
    state_d       = state_q;
    light_prev_d  = light_ns;
    req_prev_d    = ped_req;
    req_pending_d = req_pending_q | req_rise;
    walk_cnt_d    = walk_cnt_q;
    countdown_d   = countdown_q;
    aborted_d     = 1'b0;
    fault_d       = fault_q | (light_ns == L_ILLEGAL);

    unique case (state_q)
      S_DONT_WALK: begin
        // Only a request registered before this green is served now;
        // a coincident rising edge keeps the latch set for the next green.
        if (green_entry && req_pending_q && !fault_q) begin
          state_d    = S_WALK;
          walk_cnt_d = '0;
          if (!req_rise) req_pending_d = 1'b0;
        end
      end
      S_WALK: begin
        if (walk_cnt_q == WALK_LAST) begin
          state_d     = S_FLASH;
          countdown_d = FLASH_INIT;
        end else begin
          walk_cnt_d = walk_cnt_q + 4'd1;
        end
      end
      S_FLASH: begin
        if (countdown_q == 4'd1) begin
          state_d     = S_DONT_WALK;
          countdown_d = '0;
        end else begin
          countdown_d = countdown_q - 4'd1;
        end
      end
      default: begin
        state_d     = S_DONT_WALK;
        countdown_d = '0;
      end
    endcase

    // Losing green while pedestrians may be in the crosswalk cuts the phase short.
    if (in_walk_or_flash && (light_ns != L_GREEN)) begin
      state_d     = S_DONT_WALK;
      countdown_d = '0;
      aborted_d   = 1'b1;
    end

    // An illegal phase (now or earlier) pins the crossing to DON'T WALK.
    if (fault_d) begin
      state_d     = S_DONT_WALK;
      countdown_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_DONT_WALK;
      light_prev_q  <= 2'b00;
      req_prev_q    <= 1'b0;
      req_pending_q <= 1'b0;
      walk_cnt_q    <= '0;
      countdown_q   <= '0;
      aborted_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      light_prev_q  <= light_prev_d;
      req_prev_q    <= req_prev_d;
      req_pending_q <= req_pending_d;
      walk_cnt_q    <= walk_cnt_d;
      countdown_q   <= countdown_d;
      aborted_q     <= aborted_d;
      fault_q       <= fault_d;
    end
  end

  assign walk        = (state_q == S_WALK);
  assign flash       = (state_q == S_FLASH);
  assign dont_walk   = (state_q == S_DONT_WALK);
  assign countdown   = countdown_q;
  assign req_pending = req_pending_q;
  assign aborted     = aborted_q;
  assign fault       = fault_q;

endmodule
